stack_ctrl: RTL and testbench

//   LIFO controller that drives the single-port 1024x4 stack RAM (synchronous read, no output register).

---
 rtl/stack_ctrl.sv | 116 +++++++++++
 tb/tb_stack_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl.sv
// LIFO controller for a single-port synchronous-read stack RAM.
// Turns push/pop requests into RAM accesses and tracks the stack pointer and status.
module stack_ctrl #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              ready,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_do
);

  localparam int unsigned CW = ADDR_W + 1;

  typedef enum logic [0:0] {IDLE, RD} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [DATA_W-1:0]   pop_data_q, pop_data_d;
  logic                pop_valid_q, pop_valid_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic                idle_req;
  logic                push_acc;
  logic                pop_acc;
  logic [CW-1:0]       count_dec;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign ready     = (state_q == IDLE);
  assign pop_data  = pop_data_q;
  assign pop_valid = pop_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // Request acceptance: clear beats pop, pop beats push.
  assign idle_req  = (state_q == IDLE) && !clear;
  assign pop_acc   = idle_req && pop && !empty;
  assign push_acc  = idle_req && push && !pop && !full;
  assign count_dec = CW'(count_q - CW'(1));

  // RAM strobes are gated by rst_n so nothing is written while reset is asserted.
  assign ram_ce   = rst_n && (push_acc || pop_acc);
  assign ram_we   = rst_n && push_acc;
  assign ram_addr = pop_acc ? count_dec[ADDR_W-1:0] : count_q[ADDR_W-1:0];
  assign ram_di   = push_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (clear) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop_acc) begin
            count_d = count_dec;
            state_d = RD;
          end else if (push_acc) begin
            count_d = CW'(count_q + CW'(1));
          end
          underflow_d = pop && empty;
          overflow_d  = push && !pop && full;
        end
        RD: begin
          // RAM output is valid in the cycle after the read edge.
          pop_data_d  = ram_do;
          pop_valid_d = 1'b1;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed testbench for stack_ctrl with a behavioural 1024x4 synchronous-read RAM.
module tb_stack_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, clear, push, pop;
  logic [3:0]  push_data;
  logic        ready, pop_valid, full, empty, overflow, underflow;
  logic [3:0]  pop_data;
  logic [10:0] count;
  logic [9:0]  ram_addr;
  logic        ram_ce, ram_we;
  logic [3:0]  ram_di, ram_do;
  logic [3:0]  mem [1024];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stack_ctrl dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .push(push), .push_data(push_data),
    .pop(pop), .ready(ready), .pop_data(pop_data), .pop_valid(pop_valid),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .underflow(underflow), .ram_addr(ram_addr), .ram_ce(ram_ce), .ram_we(ram_we),
    .ram_di(ram_di), .ram_do(ram_do)
  );

  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) mem[ram_addr] <= ram_di;
      else        ram_do <= mem[ram_addr];
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; push_data = 4'h0;
    #1;
    n_cmp++; if (ram_ce !== 1'b0) begin n_err++; $display("FAIL reset_ce: got %b want 0", ram_ce); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    n_cmp++; if (count !== 11'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if ({empty, full, ready} !== 3'b101) begin n_err++; $display("FAIL reset_flags: got %b want 101", {empty, full, ready}); end
    n_cmp++; if ({pop_valid, overflow, underflow} !== 3'b000) begin n_err++; $display("FAIL reset_pulses: got %b want 000", {pop_valid, overflow, underflow}); end
    n_cmp++; if (pop_data !== 4'h0) begin n_err++; $display("FAIL reset_pop_data: got %h want 0", pop_data); end
  endtask

  task automatic do_push(input logic [3:0] d, input logic [10:0] exp_cnt);
    @(negedge clk) begin push = 1'b1; push_data = d; end
    #1;
    n_cmp++; if ({ram_ce, ram_we, ram_addr, ram_di} !== {2'b11, exp_cnt[9:0], d})
      begin n_err++; $display("FAIL push_ram: got ce%b we%b a%0d d%h want ce1 we1 a%0d d%h", ram_ce, ram_we, ram_addr, ram_di, exp_cnt[9:0], d); end
    @(posedge clk) #1;
    push = 1'b0;
    n_cmp++; if (count !== exp_cnt + 11'd1) begin n_err++; $display("FAIL push_count: got %0d want %0d", count, exp_cnt + 11'd1); end
  endtask

  task automatic do_pop(input logic [3:0] exp_d, input logic [10:0] exp_cnt);
    @(negedge clk) pop = 1'b1;
    #1;
    n_cmp++; if ({ram_ce, ram_we, ram_addr} !== {2'b10, 10'(exp_cnt - 11'd1)})
      begin n_err++; $display("FAIL pop_ram: got ce%b we%b a%0d want ce1 we0 a%0d", ram_ce, ram_we, ram_addr, exp_cnt - 11'd1); end
    @(posedge clk) #1;
    n_cmp++; if ({pop_valid, ready, count} !== {2'b00, 11'(exp_cnt - 11'd1)})
      begin n_err++; $display("FAIL pop_rd: got v%b rdy%b cnt%0d want v0 rdy0 cnt%0d", pop_valid, ready, count, exp_cnt - 11'd1); end
    @(negedge clk) pop = 1'b0;
    @(posedge clk) #1;
    n_cmp++; if ({pop_valid, pop_data} !== {1'b1, exp_d})
      begin n_err++; $display("FAIL pop_data: got v%b d%h want v1 d%h", pop_valid, pop_data, exp_d); end
  endtask

  task automatic do_clear();
    @(negedge clk) clear = 1'b1;
    @(posedge clk) #1;
    clear = 1'b0;
    n_cmp++; if (count !== 11'd0) begin n_err++; $display("FAIL clear_count: got %0d want 0", count); end
  endtask

  task automatic test_lifo();
    do_push(4'h1, 11'd0);
    do_push(4'h2, 11'd1);
    do_push(4'h3, 11'd2);
    do_pop(4'h3, 11'd3);
    do_pop(4'h2, 11'd2);
    do_pop(4'h1, 11'd1);
    n_cmp++; if ({empty, count} !== {1'b1, 11'd0}) begin n_err++; $display("FAIL lifo_empty: got e%b c%0d want e1 c0", empty, count); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk) begin push = 1'b1; push_data = 4'(i); end
      @(posedge clk);
    end
    @(negedge clk) push_data = 4'hA;
    #1;
    n_cmp++; if ({full, count} !== {1'b1, 11'd1024}) begin n_err++; $display("FAIL full_flag: got f%b c%0d want f1 c1024", full, count); end
    n_cmp++; if (ram_ce !== 1'b0) begin n_err++; $display("FAIL ovf_ce: got %b want 0", ram_ce); end
    @(posedge clk) #1;
    n_cmp++; if ({overflow, count} !== {1'b1, 11'd1024}) begin n_err++; $display("FAIL ovf_pulse: got o%b c%0d want o1 c1024", overflow, count); end
    @(negedge clk) push = 1'b0;
    @(posedge clk) #1;
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_end: got %b want 0", overflow); end
    do_pop(4'hF, 11'd1024);
    do_clear();
  endtask

  task automatic test_underflow();
    @(negedge clk) pop = 1'b1;
    #1;
    n_cmp++; if (ram_ce !== 1'b0) begin n_err++; $display("FAIL udf_ce: got %b want 0", ram_ce); end
    @(posedge clk) #1;
    n_cmp++; if ({underflow, pop_valid, count} !== {2'b10, 11'd0})
      begin n_err++; $display("FAIL udf_pulse: got u%b v%b c%0d want u1 v0 c0", underflow, pop_valid, count); end
    @(negedge clk) pop = 1'b0;
    @(posedge clk) #1;
    n_cmp++; if ({underflow, pop_valid} !== 2'b00) begin n_err++; $display("FAIL udf_end: got %b want 00", {underflow, pop_valid}); end
  endtask

  task automatic test_push_pop();
    do_push(4'h5, 11'd0);
    do_push(4'h6, 11'd1);
    @(negedge clk) begin push = 1'b1; pop = 1'b1; push_data = 4'h9; end
    #1;
    n_cmp++; if ({ram_ce, ram_we, ram_addr} !== {2'b10, 10'd1})
      begin n_err++; $display("FAIL pp_ram: got ce%b we%b a%0d want ce1 we0 a1", ram_ce, ram_we, ram_addr); end
    @(posedge clk) #1;
    n_cmp++; if ({count, ready, overflow} !== {11'd1, 2'b00})
      begin n_err++; $display("FAIL pp_state: got c%0d r%b o%b want c1 r0 o0", count, ready, overflow); end
    @(negedge clk) begin push = 1'b0; pop = 1'b0; end
    @(posedge clk) #1;
    n_cmp++; if ({pop_valid, pop_data, count} !== {1'b1, 4'h6, 11'd1})
      begin n_err++; $display("FAIL pp_data: got v%b d%h c%0d want v1 d6 c1", pop_valid, pop_data, count); end
    do_clear();
  endtask

  task automatic test_clear_rd();
    do_push(4'h7, 11'd0);
    @(negedge clk) pop = 1'b1;
    @(posedge clk);
    @(negedge clk) begin pop = 1'b0; clear = 1'b1; end
    #1;
    n_cmp++; if (ram_ce !== 1'b0) begin n_err++; $display("FAIL clr_ce: got %b want 0", ram_ce); end
    @(posedge clk) #1;
    clear = 1'b0;
    n_cmp++; if ({pop_valid, count, pop_data, ready} !== {1'b0, 11'd0, 4'h6, 1'b1})
      begin n_err++; $display("FAIL clr_rd: got v%b c%0d d%h r%b want v0 c0 d6 r1", pop_valid, count, pop_data, ready); end
  endtask

  task automatic test_reset_mid();
    do_push(4'h3, 11'd0);
    do_push(4'h4, 11'd1);
    @(negedge clk) pop = 1'b1;
    @(posedge clk);
    @(negedge clk) begin pop = 1'b0; push = 1'b1; push_data = 4'hC; end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({ram_ce, ram_we} !== 2'b00) begin n_err++; $display("FAIL rst_mid_ram: got %b want 00", {ram_ce, ram_we}); end
    n_cmp++; if ({count, pop_data, pop_valid, empty, full, ready} !== {11'd0, 4'h0, 4'b0101})
      begin n_err++; $display("FAIL rst_mid_state: got c%0d d%h v%b e%b f%b r%b want c0 d0 v0 e1 f0 r1", count, pop_data, pop_valid, empty, full, ready); end
    @(posedge clk) #1;
    n_cmp++; if ({ram_ce, count, pop_valid} !== {1'b0, 11'd0, 1'b0})
      begin n_err++; $display("FAIL rst_hold: got ce%b c%0d v%b want ce0 c0 v0", ram_ce, count, pop_valid); end
    @(negedge clk) begin push = 1'b0; rst_n = 1'b1; end
  endtask

  initial begin
    test_reset();
    test_lifo();
    test_full();
    test_underflow();
    test_push_pop();
    test_clear_rd();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
